md_issue_ctrl: RTL

//  Initiator side of the HI/LO multiply/divide unit interface. Sits between ID and EX: accepts decoded

---
 rtl/md_issue_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/md_issue_ctrl.sv
// Issue control for the HI/LO mult/div unit: decodes ID md ops into registered EX-stage unit controls (1 cycle ID->EX).
// Stalls ID (combinationally) while a mult/div is in flight; flushes drop an op in EX or undo it one cycle later.
module md_issue_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [3:0]  id_mdop,
    input  logic [31:0] id_rs,
    input  logic [31:0] id_rt,
    input  logic        ex_flush,
    input  logic        md_busy,
    output logic        stall_id,
    output logic        md_start,
    output logic [1:0]  md_op,
    output logic        md_we,
    output logic        md_hilo,
    output logic [31:0] md_d1,
    output logic [31:0] md_d2,
    output logic        md_int,
    output logic        md_clear,
    output logic [1:0]  mf_sel
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             mem_md;

    logic             is_mul, is_div, is_mt, is_mf;
    logic             hz, issue, flush_ex, flush_mem;

    logic             start_nxt, we_nxt, hilo_nxt;
    logic [1:0]       op_nxt, mf_nxt;
    logic [31:0]      d1_nxt, d2_nxt;

    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        is_mt  = 1'b0;
        is_mf  = 1'b0;
        case (id_mdop)
            4'd1, 4'd2: is_mul = 1'b1;
            4'd3, 4'd4: is_div = 1'b1;
            4'd5, 4'd6: is_mt  = 1'b1;
            4'd7, 4'd8: is_mf  = 1'b1;
            default:    ;
        endcase
    end

    // Only HI/LO users wait on the unit; everything else flows past it.
    assign hz        = id_valid && (is_mul || is_div || is_mt || is_mf);
    assign stall_id  = !rst && hz && ((state == BUSY) || md_busy);
    assign issue     = hz && !stall_id && !ex_flush;

    assign flush_ex  = ex_flush && (md_start || md_we);
    assign flush_mem = ex_flush && mem_md;
    assign md_int    = ex_flush;
    assign md_clear  = flush_mem;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        start_nxt = 1'b0;
        we_nxt    = 1'b0;
        mf_nxt    = 2'b00;
        op_nxt    = md_op;
        hilo_nxt  = md_hilo;
        d1_nxt    = md_d1;
        d2_nxt    = md_d2;

        if (flush_ex || flush_mem) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (issue && (is_mul || is_div)) begin
            state_nxt = BUSY;
            cnt_nxt   = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        end else if (state == BUSY) begin
            // cnt==1 is the last stalled cycle; the next op issues one cycle later.
            if (cnt <= CNT_W'(1)) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
            end
        end

        if (issue) begin
            d1_nxt = id_rs;
            d2_nxt = id_rt;
            if (is_mul || is_div) begin
                start_nxt = 1'b1;
                op_nxt    = 2'(id_mdop - 4'd1);
            end
            if (is_mt) begin
                we_nxt   = 1'b1;
                hilo_nxt = (id_mdop == 4'd5);
            end
            if (is_mf) begin
                mf_nxt = (id_mdop == 4'd7) ? 2'b01 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            mem_md   <= 1'b0;
            md_start <= 1'b0;
            md_op    <= 2'b00;
            md_we    <= 1'b0;
            md_hilo  <= 1'b0;
            md_d1    <= 32'd0;
            md_d2    <= 32'd0;
            mf_sel   <= 2'b00;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            mem_md   <= md_start || md_we;
            md_start <= start_nxt;
            md_op    <= op_nxt;
            md_we    <= we_nxt;
            md_hilo  <= hilo_nxt;
            md_d1    <= d1_nxt;
            md_d2    <= d2_nxt;
            mf_sel   <= mf_nxt;
        end
    end

endmodule
